// File: rtl/bch_serial_encoder_pkg.sv
// Shared definitions for the serial BCH encoder.
//
// Purpose : holds the encoder FSM state encoding and a small helper used to
//           size the bit counter, so the top and the remainder sub-module
//           agree on the same definitions.
// Contents: state_t  - IDLE / DATA / PARITY encoder states
//           maxOf()  - larger of two integers, for counter sizing

package bch_serial_encoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } state_t;

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bch_remainder_lfsr.sv
// Remainder register of the serial BCH encoder.
//
// Purpose : divides the incoming message polynomial (times x^M) by g(x) one bit
//           at a time, and can also shift the finished remainder out MSB first.
// Ports   : clk        - clock, rising edge
//           reset_n    - asynchronous active-low reset, clears r
//           enable     - advance the register this cycle
//           clear      - force r to zero (wins over enable)
//           shift_only - plain left shift with zero fill (parity read-out)
//           din        - message bit, highest degree first
//           r          - current remainder, r[M-1] is the x^(M-1) coefficient

module bch_remainder_lfsr
   import bch_serial_encoder_pkg::*;
#(
   parameter int           M   = 8,
   parameter logic [M-1:0] GEN = 8'hD1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         enable,
   input  logic         clear,
   input  logic         shift_only,
   input  logic         din,
   output logic [M-1:0] r
);

   logic [M-1:0] r_remainder;
   logic [M-1:0] w_shifted;
   logic         w_feedback;

   // The shift drops r[M-1]; that bit instead decides (together with the new
   // message bit) whether the generator taps are folded back in.
   always_comb begin
      w_shifted  = {r_remainder[M-2:0], 1'b0};
      w_feedback = din ^ r_remainder[M-1];
   end

   // Remainder register. Clear has priority so the last parity load can both
   // finish the read-out and leave the register ready for the next frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_remainder <= '0;
      end else if (clear) begin
         r_remainder <= '0;
      end else if (enable) begin
         if (shift_only) begin
            r_remainder <= w_shifted;
         end else begin
            r_remainder <= w_shifted ^ (w_feedback ? GEN : '0);
         end
      end
   end

   assign r = r_remainder;

endmodule

// File: rtl/bch_serial_encoder.sv
// Bit-serial systematic BCH encoder.
//
// Purpose : passes DATA_BITS message bits straight through, then appends the
//           ECC_BITS parity bits (remainder of m(x)*x^M mod g(x), MSB first).
//           Input and output use valid/ready handshakes; the output stage is a
//           single register slice.
// Ports   : clk, reset_n            - clock (rising edge), async active-low reset
//           in_data/in_valid/in_ready - message bit stream, highest degree first
//           out_data/out_valid/out_ready - codeword bit stream
//           out_parity             - current out_data is a parity bit
//           out_last               - current out_data ends the codeword

module bch_serial_encoder
   import bch_serial_encoder_pkg::*;
#(
   parameter int                  DATA_BITS = 7,
   parameter int                  ECC_BITS  = 8,
   parameter logic [ECC_BITS-1:0] GEN       = 8'hD1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_data,
   input  logic in_valid,
   output logic in_ready,
   output logic out_data,
   output logic out_valid,
   input  logic out_ready,
   output logic out_parity,
   output logic out_last
);

   localparam int            CW          = $clog2(maxOf(DATA_BITS, ECC_BITS) + 1);
   localparam logic [CW-1:0] LAST_DATA   = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] LAST_PARITY = CW'(ECC_BITS - 1);
   localparam logic [CW-1:0] COUNT_ONE   = CW'(1);

   state_t                r_state;
   state_t                w_nextState;
   logic [CW-1:0]         r_count;
   logic [CW-1:0]         w_nextCount;
   logic                  w_load;
   logic                  w_accept;
   logic                  w_parityLoad;
   logic                  w_lastParity;
   logic                  w_lfsrEnable;
   logic                  w_lfsrClear;
   logic [ECC_BITS-1:0]   w_remainder;

   // State and bit counter register; counts message bits in DATA and parity
   // bits in PARITY.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_nextState;
         r_count <= w_nextCount;
      end
   end

   // Next-state logic. A one-bit message skips DATA entirely; the last parity
   // load goes straight back to IDLE so the next frame can start on the
   // following cycle.
   always_comb begin
      w_nextState = r_state;
      w_nextCount = r_count;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (DATA_BITS == 1) begin
                  w_nextState = PARITY;
                  w_nextCount = '0;
               end else begin
                  w_nextState = DATA;
                  w_nextCount = COUNT_ONE;
               end
            end
         end
         DATA: begin
            if (w_accept) begin
               if (r_count == LAST_DATA) begin
                  w_nextState = PARITY;
                  w_nextCount = '0;
               end else begin
                  w_nextCount = r_count + COUNT_ONE;
               end
            end
         end
         PARITY: begin
            if (w_load) begin
               if (r_count == LAST_PARITY) begin
                  w_nextState = IDLE;
                  w_nextCount = '0;
               end else begin
                  w_nextCount = r_count + COUNT_ONE;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextCount = '0;
         end
      endcase
   end

   // Handshake and remainder control. The output slice can take a new bit
   // whenever it is empty or being drained; input is refused while parity is
   // being read out.
   always_comb begin
      w_load       = !out_valid || out_ready;
      in_ready     = w_load && (r_state != PARITY);
      w_accept     = in_valid && in_ready;
      w_parityLoad = w_load && (r_state == PARITY);
      w_lastParity = w_parityLoad && (r_count == LAST_PARITY);
      w_lfsrEnable = w_accept || w_parityLoad;
      w_lfsrClear  = w_lastParity;
   end

   bch_remainder_lfsr #(
      .M   (ECC_BITS),
      .GEN (GEN)
   ) u_remainder (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (w_lfsrEnable),
      .clear      (w_lfsrClear),
      .shift_only (r_state == PARITY),
      .din        (in_data),
      .r          (w_remainder)
   );

   // Registered output slice. It only changes on a load, so a stalled sink
   // sees a stable bit and flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_data   <= 1'b0;
         out_parity <= 1'b0;
         out_last   <= 1'b0;
      end else if (w_load) begin
         out_valid  <= w_accept || w_parityLoad;
         out_data   <= w_parityLoad ? w_remainder[ECC_BITS-1] : in_data;
         out_parity <= w_parityLoad;
         out_last   <= w_lastParity;
      end
   end

   // Outside a frame the remainder must already be cleared, otherwise the next
   // codeword would inherit stale parity.
   idleRemainderClear : assert property (
      @(posedge clk) disable iff (!reset_n)
      (r_state == IDLE) |-> (w_remainder == '0)
   );

endmodule

// File: tb/tb_bch_serial_encoder.sv
// Self-checking bench for bch_serial_encoder (K=7, M=8, g = x^8 + 0xD1).
// Expected codewords come from a polynomial long-division model.

module tb_bch_serial_encoder;

   localparam int            K   = 7;
   localparam int            M   = 8;
   localparam int            N   = K + M;
   localparam logic [M-1:0]  GEN = 8'hD1;

   logic clk;
   logic reset_n;
   logic in_data;
   logic in_valid;
   logic in_ready;
   logic out_data;
   logic out_valid;
   logic out_ready;
   logic out_parity;
   logic out_last;

   int checks;
   int passes;
   int lowCount;
   int firstCycle;
   int lastCycle;
   logic [N-1:0] lastWord;
   logic [K-1:0] msgQ[$];

   bch_serial_encoder #(
      .DATA_BITS (K),
      .ECC_BITS  (M),
      .GEN       (GEN)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_parity (out_parity),
      .out_last   (out_last)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Remainder of a polynomial modulo g(x) by schoolbook long division.
   function automatic logic [M-1:0] polyMod(input logic [N-1:0] dividend);
      logic [N-1:0] d;
      logic [N-1:0] g;
      d = dividend;
      g = {{(K-1){1'b0}}, 1'b1, GEN};
      for (int deg = N - 1; deg >= M; deg--) begin
         if (d[deg]) d = d ^ (g << (deg - M));
      end
      return d[M-1:0];
   endfunction

   // Systematic codeword: message on top, remainder of m(x)*x^M below.
   function automatic logic [N-1:0] encodeModel(input logic [K-1:0] msg);
      return {msg, polyMod({msg, {M{1'b0}}})};
   endfunction

   // Single comparison point; every check is counted here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive all inputs for one cycle.
   task automatic applyStimulus(input logic valid, input logic data, input logic ready);
      in_valid  = valid;
      in_data   = data;
      out_ready = ready;
   endtask

   // Streams every message in msgQ through the encoder and compares the
   // consumed output against the model. stallAt >= 0 holds out_ready low for
   // five cycles when that output index is being presented.
   task automatic runStream(input string tag, input bit randomReady,
                            input bit randomValid, input int stallAt);
      bit           inBits[$];
      bit           expData[$];
      bit           expPar[$];
      bit           expLast[$];
      bit           gotData[$];
      bit           gotPar[$];
      bit           gotLast[$];
      int           inIdx;
      int           cycle;
      int           stallCount;
      int           budget;
      logic         valid;
      logic         data;
      logic         ready;
      logic [N-1:0] cw;
      logic [N-1:0] gw, gp, gl, ep, el;
      inIdx      = 0;
      cycle      = 0;
      stallCount = 0;
      foreach (msgQ[f]) begin
         cw = encodeModel(msgQ[f]);
         for (int b = N - 1; b >= 0; b--) begin
            if (b >= M) inBits.push_back(cw[b]);
            expData.push_back(cw[b]);
            expPar.push_back(b < M);
            expLast.push_back(b == 0);
         end
      end
      budget     = expData.size() * 10 + 50;
      lowCount   = 0;
      firstCycle = -1;
      lastCycle  = -1;
      while (gotData.size() < expData.size() && cycle < budget) begin
         @(negedge clk);
         if (stallAt >= 0 && stallCount < 5 && gotData.size() == stallAt && out_valid) begin
            ready = 1'b0;
            stallCount++;
            checkOutput($sformatf("%s stall%0d data", tag, stallCount), out_data, expData[stallAt]);
            checkOutput($sformatf("%s stall%0d parity", tag, stallCount), out_parity, expPar[stallAt]);
            checkOutput($sformatf("%s stall%0d last", tag, stallCount), out_last, expLast[stallAt]);
         end else begin
            ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         valid = (inIdx < inBits.size()) && (!randomValid || $urandom_range(0, 3) != 0);
         data  = valid ? inBits[inIdx] : 1'($urandom_range(0, 1));
         applyStimulus(valid, data, ready);
         #1;
         if (!in_ready) lowCount++;
         if (in_valid && in_ready) inIdx++;
         if (out_valid && out_ready) begin
            gotData.push_back(out_data);
            gotPar.push_back(out_parity);
            gotLast.push_back(out_last);
            if (firstCycle < 0) firstCycle = cycle;
            lastCycle = cycle;
         end
         cycle++;
      end
      checkOutput($sformatf("%s bit count", tag), gotData.size(), expData.size());
      foreach (msgQ[f]) begin
         gw = '0; gp = '0; gl = '0; ep = '0; el = '0;
         for (int b = 0; b < N; b++) begin
            int idx;
            idx = f * N + b;
            gw  = {gw[N-2:0], (idx < gotData.size()) ? gotData[idx] : 1'b0};
            gp  = {gp[N-2:0], (idx < gotPar.size())  ? gotPar[idx]  : 1'b0};
            gl  = {gl[N-2:0], (idx < gotLast.size()) ? gotLast[idx] : 1'b0};
            ep  = {ep[N-2:0], expPar[idx]};
            el  = {el[N-2:0], expLast[idx]};
         end
         checkOutput($sformatf("%s f%0d codeword", tag, f), gw, encodeModel(msgQ[f]));
         checkOutput($sformatf("%s f%0d parity flags", tag, f), gp, ep);
         checkOutput($sformatf("%s f%0d last flags", tag, f), gl, el);
         checkOutput($sformatf("%s f%0d divisible", tag, f), polyMod(gw), 0);
         lastWord = gw;
      end
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b1);
      #1;
      checkOutput($sformatf("%s no extra bit", tag), out_valid, 1'b0);
   endtask

   // Feeds four message bits, then pulses reset between clock edges.
   task automatic resetMidFrame();
      int budget;
      int accepted;
      budget   = 0;
      accepted = 0;
      while (accepted < 4 && budget < 50) begin
         @(negedge clk);
         applyStimulus(1'b1, 1'b1, 1'b1);
         #1;
         if (in_ready) accepted++;
         budget++;
      end
      checkOutput("pre-reset bits accepted", accepted, 4);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("mid reset out_valid", out_valid, 1'b0);
      checkOutput("mid reset out_data", out_data, 1'b0);
      checkOutput("mid reset out_parity", out_parity, 1'b0);
      checkOutput("mid reset out_last", out_last, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b1);
      reset_n = 1'b1;
   endtask

   initial begin
      checks  = 0;
      passes  = 0;
      reset_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1);
      #1;
      reset_n = 1'b0;
      #2;
      checkOutput("reset out_valid", out_valid, 1'b0);
      checkOutput("reset out_data", out_data, 1'b0);
      checkOutput("reset out_parity", out_parity, 1'b0);
      checkOutput("reset out_last", out_last, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("in_ready after reset", in_ready, 1'b1);

      msgQ = {7'b0000000};
      runStream("zero msg", 1'b0, 1'b0, -1);

      msgQ = {7'b0000001};
      runStream("one msg stall", 1'b0, 1'b0, 10);
      checkOutput("one msg parity", lastWord[M-1:0], 8'hD1);

      msgQ = {7'($urandom_range(0, 127)), 7'($urandom_range(0, 127))};
      runStream("b2b", 1'b0, 1'b0, -1);
      checkOutput("b2b in_ready low cycles", lowCount, 16);
      checkOutput("b2b output span", lastCycle - firstCycle, 2 * N - 1);

      msgQ = {};
      for (int i = 0; i < 20; i++) msgQ.push_back(7'($urandom_range(0, 127)));
      runStream("random", 1'b1, 1'b1, -1);

      resetMidFrame();
      msgQ = {7'b0000001};
      runStream("post reset", 1'b0, 1'b0, -1);
      checkOutput("post reset parity", lastWord[M-1:0], 8'hD1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
